// File: rtl/tournament_update_queue_if.sv
// rtl/tournament_update_queue_if.sv - prediction/resolve/update bundle for the tournament update queue
interface tournament_update_queue_if #(
  parameter int HIST_W = 12,
  parameter int PC_W   = 10,
  parameter int DEPTH  = 8
);
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic              pred_valid;
  logic              pred_ready;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_local;
  logic              pred_global;
  logic              pred_choice;
  logic              resolve_valid;
  logic              resolve_taken;
  logic [HIST_W-1:0] global_history;
  logic              upd_valid;
  logic [HIST_W-1:0] upd_index;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic              upd_choice_en;
  logic              upd_choice_dir;
  logic              mispredict;
  logic              underflow_err;
  logic [OCC_W-1:0]  occupancy;

  modport slave (
    input  pred_valid, pred_pc, pred_local, pred_global, pred_choice,
    input  resolve_valid, resolve_taken,
    output pred_ready, global_history,
    output upd_valid, upd_index, upd_pc, upd_taken, upd_choice_en, upd_choice_dir,
    output mispredict, underflow_err, occupancy
  );

  modport master (
    output pred_valid, pred_pc, pred_local, pred_global, pred_choice,
    output resolve_valid, resolve_taken,
    input  pred_ready, global_history,
    input  upd_valid, upd_index, upd_pc, upd_taken, upd_choice_en, upd_choice_dir,
    input  mispredict, underflow_err, occupancy
  );
endinterface

// File: rtl/tournament_update_queue.sv
// rtl/tournament_update_queue.sv - in-flight tournament prediction queue, speculative GHR and table update issue
module tournament_update_queue #(
  parameter int HIST_W = 12,
  parameter int PC_W   = 10,
  parameter int DEPTH  = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  tournament_update_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

  // Entry storage carries no reset; validity is defined by the pointers and occupancy.
  logic [PC_W-1:0]   pc_mem_q     [DEPTH];
  logic              local_mem_q  [DEPTH];
  logic              global_mem_q [DEPTH];
  logic              fp_mem_q     [DEPTH];
  logic [HIST_W-1:0] ckpt_mem_q   [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [HIST_W-1:0] ghr_q, ghr_d;
  logic              ready_q, ready_d;
  logic              upd_valid_q, upd_valid_d;
  logic [HIST_W-1:0] upd_index_q, upd_index_d;
  logic [PC_W-1:0]   upd_pc_q, upd_pc_d;
  logic              upd_taken_q, upd_taken_d;
  logic              upd_choice_en_q, upd_choice_en_d;
  logic              upd_choice_dir_q, upd_choice_dir_d;
  logic              mispredict_q, mispredict_d;
  logic              underflow_q, underflow_d;

  logic              enq;
  logic              enq_fp;
  logic              empty;
  logic              res;
  logic              mis;
  logic              mem_we;
  logic [PC_W-1:0]   head_pc;
  logic              head_local;
  logic              head_global;
  logic              head_fp;
  logic [HIST_W-1:0] head_ckpt;

  always_comb begin
    enq         = bus.pred_valid && ready_q;
    enq_fp      = bus.pred_choice ? bus.pred_global : bus.pred_local;
    empty       = (occ_q == '0);
    res         = bus.resolve_valid && !empty;
    head_pc     = pc_mem_q[rd_ptr_q];
    head_local  = local_mem_q[rd_ptr_q];
    head_global = global_mem_q[rd_ptr_q];
    head_fp     = fp_mem_q[rd_ptr_q];
    head_ckpt   = ckpt_mem_q[rd_ptr_q];
    mis         = res && (head_fp != bus.resolve_taken);
    mem_we      = enq && !mis;
  end

  always_comb begin
    rd_ptr_d         = rd_ptr_q;
    wr_ptr_d         = wr_ptr_q;
    occ_d            = occ_q;
    ghr_d            = ghr_q;
    upd_valid_d      = 1'b0;
    upd_index_d      = upd_index_q;
    upd_pc_d         = upd_pc_q;
    upd_taken_d      = upd_taken_q;
    upd_choice_en_d  = upd_choice_en_q;
    upd_choice_dir_d = upd_choice_dir_q;
    mispredict_d     = 1'b0;
    underflow_d      = bus.resolve_valid && empty;

    if (res) begin
      rd_ptr_d         = rd_ptr_q + PTR_W'(1);
      upd_valid_d      = 1'b1;
      upd_index_d      = head_ckpt;
      upd_pc_d         = head_pc;
      upd_taken_d      = bus.resolve_taken;
      upd_choice_en_d  = (head_local != head_global);
      upd_choice_dir_d = (head_global == bus.resolve_taken);
    end

    // A mispredict flushes everything younger, including a same-cycle enqueue.
    if (mis) begin
      mispredict_d = 1'b1;
      wr_ptr_d     = rd_ptr_q + PTR_W'(1);
      occ_d        = '0;
      ghr_d        = {head_ckpt[HIST_W-2:0], bus.resolve_taken};
    end else begin
      if (enq) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        ghr_d    = {ghr_q[HIST_W-2:0], enq_fp};
      end
      occ_d = occ_q + OCC_W'(enq) - OCC_W'(res);
    end

    ready_d = (occ_d < DEPTH_C);
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      pc_mem_q[wr_ptr_q]     <= bus.pred_pc;
      local_mem_q[wr_ptr_q]  <= bus.pred_local;
      global_mem_q[wr_ptr_q] <= bus.pred_global;
      fp_mem_q[wr_ptr_q]     <= enq_fp;
      ckpt_mem_q[wr_ptr_q]   <= ghr_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      occ_q            <= '0;
      ghr_q            <= '0;
      ready_q          <= 1'b1;
      upd_valid_q      <= 1'b0;
      upd_index_q      <= '0;
      upd_pc_q         <= '0;
      upd_taken_q      <= 1'b0;
      upd_choice_en_q  <= 1'b0;
      upd_choice_dir_q <= 1'b0;
      mispredict_q     <= 1'b0;
      underflow_q      <= 1'b0;
    end else begin
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      occ_q            <= occ_d;
      ghr_q            <= ghr_d;
      ready_q          <= ready_d;
      upd_valid_q      <= upd_valid_d;
      upd_index_q      <= upd_index_d;
      upd_pc_q         <= upd_pc_d;
      upd_taken_q      <= upd_taken_d;
      upd_choice_en_q  <= upd_choice_en_d;
      upd_choice_dir_q <= upd_choice_dir_d;
      mispredict_q     <= mispredict_d;
      underflow_q      <= underflow_d;
    end
  end

  assign bus.pred_ready     = ready_q;
  assign bus.global_history = ghr_q;
  assign bus.occupancy      = occ_q;
  assign bus.upd_valid      = upd_valid_q;
  assign bus.upd_index      = upd_index_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_taken      = upd_taken_q;
  assign bus.upd_choice_en  = upd_choice_en_q;
  assign bus.upd_choice_dir = upd_choice_dir_q;
  assign bus.mispredict     = mispredict_q;
  assign bus.underflow_err  = underflow_q;
endmodule

// File: tb/tb_tournament_update_queue.sv
// tb/tb_tournament_update_queue.sv - directed and randomized checks of tournament_update_queue against a queue model
module tb_tournament_update_queue;
  localparam int HIST_W = 12;
  localparam int PC_W   = 10;
  localparam int DEPTH  = 8;
  localparam int MASK   = (1 << HIST_W) - 1;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  tournament_update_queue_if #(.HIST_W(HIST_W), .PC_W(PC_W), .DEPTH(DEPTH)) bus ();

  tournament_update_queue #(.HIST_W(HIST_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int unsigned pc;
    bit          l;
    bit          g;
    bit          fp;
    int unsigned ckpt;
  } ent_t;

  ent_t        mq[$];
  int unsigned m_ghr;
  bit          e_uv, e_mis, e_under, e_taken, e_cen, e_cdir;
  int unsigned e_idx, e_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit head_fp();
    return (mq.size() != 0) ? mq[0].fp : 1'b0;
  endfunction

  task automatic check_all();
    check("ready", bus.pred_ready, (mq.size() < DEPTH));
    check("ghr", bus.global_history, m_ghr);
    check("occupancy", bus.occupancy, mq.size());
    check("upd_valid", bus.upd_valid, e_uv);
    check("mispredict", bus.mispredict, e_mis);
    check("underflow", bus.underflow_err, e_under);
    if (e_uv) begin
      check("upd_index", bus.upd_index, e_idx);
      check("upd_pc", bus.upd_pc, e_pc);
      check("upd_taken", bus.upd_taken, e_taken);
      check("choice_en", bus.upd_choice_en, e_cen);
      check("choice_dir", bus.upd_choice_dir, e_cdir);
    end
  endtask

  task automatic step(input bit pv, input int unsigned pc, input bit l, input bit g, input bit c,
                      input bit rv, input bit rt);
    bit          ready, enq, fp;
    int unsigned g_old;
    ent_t        h;
    bus.pred_valid    = pv;
    bus.pred_pc       = PC_W'(pc);
    bus.pred_local    = l;
    bus.pred_global   = g;
    bus.pred_choice   = c;
    bus.resolve_valid = rv;
    bus.resolve_taken = rt;
    @(posedge clock);
    ready   = (mq.size() < DEPTH);
    enq     = pv && ready;
    fp      = c ? g : l;
    g_old   = m_ghr;
    e_uv    = 1'b0;
    e_mis   = 1'b0;
    e_under = 1'b0;
    if (rv && mq.size() == 0) begin
      e_under = 1'b1;
    end else if (rv) begin
      h       = mq.pop_front();
      e_uv    = 1'b1;
      e_idx   = h.ckpt;
      e_pc    = h.pc;
      e_taken = rt;
      e_cen   = (h.l != h.g);
      e_cdir  = (h.g == rt);
      if (h.fp != rt) begin
        e_mis = 1'b1;
        mq.delete();
        m_ghr = ((h.ckpt << 1) | rt) & MASK;
      end
    end
    if (enq && !e_mis) begin
      mq.push_back('{pc: pc % (1 << PC_W), l: l, g: g, fp: fp, ckpt: g_old});
      m_ghr = ((g_old << 1) | fp) & MASK;
    end
    #1;
    check_all();
  endtask

  task automatic step_fp(input bit pv, input bit fp, input bit rv, input bit rt);
    bit c, l, g;
    c = 1'($urandom);
    l = c ? 1'($urandom) : fp;
    g = c ? fp : 1'($urandom);
    step(pv, $urandom, l, g, c, rv, rt);
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.pred_valid    = 1'b1;
    bus.resolve_valid = 1'b1;
    bus.resolve_taken = 1'($urandom);
    @(posedge clock);
    mq.delete();
    m_ghr   = 0;
    e_uv    = 1'b0;
    e_mis   = 1'b0;
    e_under = 1'b0;
    #1;
    check_all();
    check("rst_upd_index", bus.upd_index, 0);
    check("rst_upd_pc", bus.upd_pc, 0);
    reset             = 1'b0;
    bus.pred_valid    = 1'b0;
    bus.resolve_valid = 1'b0;
  endtask

  initial begin
    int unsigned g0;
    reset             = 1'b1;
    bus.pred_valid    = 1'b0;
    bus.pred_pc       = '0;
    bus.pred_local    = 1'b0;
    bus.pred_global   = 1'b0;
    bus.pred_choice   = 1'b0;
    bus.resolve_valid = 1'b0;
    bus.resolve_taken = 1'b0;

    // 1) three taken predictions
    do_reset();
    for (int i = 0; i < 3; i++) step_fp(1, 1, 0, 0);
    check("t1_ghr", bus.global_history, 12'h007);
    check("t1_occ", bus.occupancy, 3);

    // 2) choice training when components disagree
    do_reset();
    step(1, 10'h155, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    check("t2_uv", bus.upd_valid, 1);
    check("t2_cen", bus.upd_choice_en, 1);
    check("t2_cdir", bus.upd_choice_dir, 1);
    check("t2_mis", bus.mispredict, 0);
    check("t2_pc", bus.upd_pc, 10'h155);

    // 3) mispredict restores GHR from checkpoint
    do_reset();
    step_fp(1, 1, 0, 0);
    step_fp(1, 0, 0, 0);
    step_fp(1, 1, 0, 0);
    step_fp(0, 0, 1, 1);
    step_fp(0, 0, 1, 0);
    step_fp(0, 0, 1, 1);
    check("t3_ghr5", bus.global_history, 12'h005);
    step_fp(1, 1, 0, 0);
    step_fp(1, 0, 0, 0);
    step_fp(0, 0, 1, 0);
    check("t3_mis", bus.mispredict, 1);
    check("t3_idx", bus.upd_index, 12'h005);
    check("t3_ghr", bus.global_history, 12'h00A);
    check("t3_occ", bus.occupancy, 0);

    // 4) full queue backpressure
    do_reset();
    for (int i = 0; i < DEPTH; i++) step_fp(1, 1'($urandom), 0, 0);
    check("t4_ready0", bus.pred_ready, 0);
    step_fp(1, 1, 0, 0);
    check("t4_occ8", bus.occupancy, DEPTH);
    step_fp(0, 0, 1, head_fp());
    check("t4_ready1", bus.pred_ready, 1);
    check("t4_occ7", bus.occupancy, DEPTH - 1);

    // 5) same-cycle enqueue and resolve
    do_reset();
    for (int i = 0; i < 4; i++) step_fp(1, 1'($urandom), 0, 0);
    g0 = m_ghr;
    step_fp(1, 1, 1, head_fp());
    check("t5_occ4", bus.occupancy, 4);
    check("t5_ghr", bus.global_history, ((g0 << 1) | 1) & MASK);
    step_fp(1, 1, 1, !head_fp());
    check("t5_occ0", bus.occupancy, 0);
    check("t5_mis", bus.mispredict, 1);

    // 6) underflow, then reset while busy
    g0 = m_ghr;
    step_fp(0, 0, 1, 1);
    check("t6_under", bus.underflow_err, 1);
    check("t6_uv", bus.upd_valid, 0);
    check("t6_ghr", bus.global_history, g0);
    for (int i = 0; i < 5; i++) step_fp(1, 1'($urandom), 0, 0);
    check("t6_occ5", bus.occupancy, 5);
    do_reset();
    check("t6_rst_occ", bus.occupancy, 0);
    check("t6_rst_ghr", bus.global_history, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit pv, rv, rt;
      pv = ($urandom % 4) != 0;
      rv = ($urandom % 3) == 0;
      rt = (($urandom % 6) == 0) ? !head_fp() : head_fp();
      if (($urandom % 200) == 0) do_reset();
      else step_fp(pv, 1'($urandom), rv, rt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
